uart_tx_arbiter: RTL and testbench

// - Shares the single UART TX byte channel (d_tx/vld_tx/rdy_tx) among N_REQ byte sources, e.g. echo path, debug dump, status reporter.
// - Arbitrates round-robin at packet granularity: a requester keeps the channel until its byte flagged last is accepted.
// - A watchdog releases stalled packets.
// - Sits between the source modules and TX, in the 100 MHz clk domain; rdy_tx is delivered already in the clk domain.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART TX arbiter: FSM encoding, byte width,
// default watchdog span and the held-byte record.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_byte_t;

  // One-hot (up to 8 requesters) to binary index.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching from ptr+1
// upward, wrapping modulo N_REQ; one-hot result, all-zero when nothing requests.
module rr_pick import uart_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte channel, with an
// idle watchdog. Define UART_ARB_PRIO_EN to let requester 0 win every arbitration.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [BYTE_W-1:0]       d_tx,
  output logic                    vld_tx,
  input  logic                    rdy_tx,
  output logic [N_REQ-1:0]        grant,
  output logic                    timeout
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [0:0]                    state;
  logic [PTR_W-1:0]              rr_ptr, g_idx, win_idx;
  tx_byte_t                      out_q;
  logic                          out_vld;
  logic [TO_W-1:0]               to_cnt;
  logic [N_REQ-1:0][BYTE_W-1:0]  req_bytes;
  logic [N_REQ-1:0]              rr_win, win;
  logic                          locked, take_ok, take, tx_acc, pkt_end, stall, expire;

  assign req_bytes = req_data;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .win (rr_win)
  );

`ifdef UART_ARB_PRIO_EN
  assign win = req_vld[0] ? N_REQ'(1) : rr_win;
`else
  assign win = rr_win;
`endif

  assign win_idx = PTR_W'(oh2idx(8'(win)));

  // Once the last byte sits in the output register the owner gets no further
  // ready, so a following packet cannot slip in under the same grant.
  assign locked  = (state == ST_LOCK);
  assign take_ok = locked && (!out_vld || rdy_tx) && !(out_vld && out_q.last);
  assign take    = take_ok && req_vld[g_idx];
  assign tx_acc  = out_vld && rdy_tx;
  assign pkt_end = locked && tx_acc && out_q.last;
  assign stall   = locked && !req_vld[g_idx] && !out_vld;
  assign expire  = stall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign req_rdy[i] = take_ok && (g_idx == PTR_W'(i));
    assign grant[i]   = locked && (g_idx == PTR_W'(i));
  end

  assign vld_tx = out_vld;
  assign d_tx   = out_q.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= PTR_W'(N_REQ - 1);
      g_idx   <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      to_cnt  <= (stall && !expire) ? to_cnt + 1'b1 : '0;

      if (take) begin
        out_q   <= '{last: req_last[g_idx], data: req_bytes[g_idx]};
        out_vld <= 1'b1;
      end else if (tx_acc) begin
        out_vld <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (|req_vld) begin
            state <= ST_LOCK;
            g_idx <= win_idx;
          end
        end
        default: begin
          if (pkt_end || expire) begin
            state  <= ST_IDLE;
            rr_ptr <= g_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic, all checked every cycle against a transaction-level channel model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_vld = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_rdy;
  logic [7:0]     d_tx;
  logic           vld_tx;
  logic           rdy_tx = 1'b0;
  logic [N-1:0]   grant;
  logic           timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx), .grant(grant),
    .timeout(timeout)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  int gap_pct = 0, rdy_pct = 100;

  // sources: per-requester byte queues ({last,data}) and the byte currently offered
  logic [8:0]         srcq [N][$];
  logic [N-1:0]       cur_vld = '0;
  logic [N-1:0][8:0]  cur_byte = '0;

  // channel model: who owns the channel, what sits in the TX register, idle run length
  logic       m_locked, m_held, m_pulse;
  int         m_owner, m_last, m_stall;
  logic [8:0] m_hbyte;

  logic [7:0] log_b[$];
  int         log_c[$], log_g[$], pulse_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef UART_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  function automatic logic busy();
    logic b;
    b = m_locked || m_held || (|cur_vld);
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic clear_logs();
    log_b.delete(); log_c.delete(); log_g.delete(); pulse_c.delete();
  endtask

  task automatic run_cycle();
    logic [N-1:0] ev, erdy;
    logic         hs, acc;
    int           o;
    @(posedge clk); cyc++; #1;
    for (int i = 0; i < N; i++)
      if (!cur_vld[i] && srcq[i].size() != 0 && $urandom_range(99, 0) >= gap_pct) begin
        cur_vld[i]  = 1'b1;
        cur_byte[i] = srcq[i].pop_front();
      end
    for (int i = 0; i < N; i++) begin
      req_vld[i]       = cur_vld[i];
      req_data[8*i+:8] = cur_byte[i][7:0];
      req_last[i]      = cur_byte[i][8];
    end
    rdy_tx = ($urandom_range(99, 0) < rdy_pct);
    #1;
    erdy = '0;
    if (m_locked && (!m_held || rdy_tx) && !(m_held && m_hbyte[8])) erdy[m_owner] = 1'b1;
    chk("grant", 32'(grant), m_locked ? (32'd1 << m_owner) : 32'd0);
    chk("req_rdy", 32'(req_rdy), 32'(erdy));
    chk("vld_tx", 32'(vld_tx), 32'(m_held));
    if (m_held) chk("d_tx", 32'(d_tx), 32'(m_hbyte[7:0]));
    chk("timeout", 32'(timeout), 32'(m_pulse));
    if (vld_tx && rdy_tx) begin
      log_b.push_back(d_tx); log_c.push_back(cyc); log_g.push_back(int'(grant));
    end
    if (timeout) pulse_c.push_back(cyc);
    // advance the model from the bench's own drive
    ev  = cur_vld;
    o   = m_owner;
    hs  = m_locked && ev[o] && erdy[o];
    acc = m_held && rdy_tx;
    m_pulse = 1'b0;
    if (!m_locked) begin
      if (|ev) begin m_owner = pick(ev, m_last); m_locked = 1'b1; m_stall = 0; end
    end else if (acc && m_hbyte[8]) begin
      m_locked = 1'b0; m_last = o;
    end else if (!ev[o] && !m_held) begin
      m_stall++;
      if (m_stall == TO) begin m_locked = 1'b0; m_last = o; m_pulse = 1'b1; m_stall = 0; end
    end else begin
      m_stall = 0;
    end
    if (hs) begin m_held = 1'b1; m_hbyte = cur_byte[o]; end
    else if (acc) m_held = 1'b0;
    for (int i = 0; i < N; i++) if (cur_vld[i] && req_rdy[i]) cur_vld[i] = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    do begin run_cycle(); n++; end while (busy() && n < maxc);
    chk({tag, "_drained"}, 32'(busy()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    cur_vld = '0; req_vld = '0; rdy_tx = 1'b0;
    @(posedge clk); cyc++; #1;
    chk("rst_vld_tx", 32'(vld_tx), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_d_tx", 32'(d_tx), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    rst = 1'b1;
    m_locked = 1'b0; m_held = 1'b0; m_pulse = 1'b0; m_stall = 0;
    m_last = N - 1; m_owner = 0; m_hbyte = '0;
    gap_pct = 0; rdy_pct = 100;
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int c0, total;
    logic [7:0] exp3 [5];
    int         expg3 [5];

    // reset state
    do_reset();
    run_cycle();

    // single packet on requester 1, latency and back-to-back bytes
    srcq[1] = {9'h041, 9'h142};
    c0 = cyc + 1;
    drain("t2", 40);
    chk("t2_count", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2) begin
      chk("t2_b0", 32'(log_b[0]), 32'h41);
      chk("t2_b1", 32'(log_b[1]), 32'h42);
      chk("t2_lat0", 32'(log_c[0] - c0), 32'd2);
      chk("t2_lat1", 32'(log_c[1] - c0), 32'd3);
      chk("t2_grant", 32'(log_g[0]), 32'b0010);
    end
    run_cycle();

    // four requesters with 1-byte packets, requester 0 queues a second one
    do_reset();
    srcq[0] = {9'h180, 9'h184}; srcq[1] = {9'h181}; srcq[2] = {9'h182}; srcq[3] = {9'h183};
`ifdef UART_ARB_PRIO_EN
    exp3 = '{8'h80, 8'h84, 8'h81, 8'h82, 8'h83};
    expg3 = '{1, 1, 2, 4, 8};
`else
    exp3 = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84};
    expg3 = '{1, 2, 4, 8, 1};
`endif
    drain("t3", 100);
    chk("t3_count", 32'(log_b.size()), 32'd5);
    if (log_b.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk("t3_byte", 32'(log_b[k]), 32'(exp3[k]));
        chk("t3_grant", 32'(log_g[k]), 32'(expg3[k]));
      end

    // back-pressure for 20 cycles mid-packet
    do_reset();
    srcq[1] = {9'h051, 9'h052, 9'h053, 9'h154};
    repeat (3) run_cycle();
    rdy_pct = 0;
    repeat (20) run_cycle();
    chk("t4_hold_d", 32'(d_tx), 32'h52);
    chk("t4_hold_vld", 32'(vld_tx), 32'd1);
    chk("t4_hold_rdy", 32'(req_rdy), 32'd0);
    rdy_pct = 100;
    drain("t4", 60);
    chk("t4_count", 32'(log_b.size()), 32'd4);
    if (log_b.size() == 4)
      for (int k = 0; k < 4; k++) chk("t4_byte", 32'(log_b[k]), 32'h51 + 32'(k));

    // watchdog: requester 2 stalls mid-packet, requester 3 waits
    do_reset();
    srcq[2] = {9'h010};
    srcq[3] = {9'h130};
    drain("t5", 300);
    chk("t5_pulses", 32'(pulse_c.size()), 32'd1);
    chk("t5_count", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2 && pulse_c.size() == 1) begin
      chk("t5_b0", 32'(log_b[0]), 32'h10);
      chk("t5_delay", 32'(pulse_c[0] - log_c[0] - 1), 32'(TO));
      chk("t5_b1", 32'(log_b[1]), 32'h30);
      chk("t5_next_grant", 32'(log_g[1]), 32'b1000);
    end

    // reset while a byte is held, then arbitration restarts from requester 0
    do_reset();
    srcq[1] = {9'h061, 9'h062, 9'h163};
    rdy_pct = 0;
    repeat (3) run_cycle();
    chk("t6_pre_vld", 32'(vld_tx), 32'd1);
    do_reset();
    srcq[1] = {9'h171}; srcq[3] = {9'h173};
    drain("t6", 60);
    chk("t6_count", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2) begin
      chk("t6_first", 32'(log_b[0]), 32'h71);
      chk("t6_first_grant", 32'(log_g[0]), 32'b0010);
    end

    // rr pointer left at 0, then requesters 0 and 2 pending together
    do_reset();
    srcq[0] = {9'h1a0};
    drain("t7a", 40);
    clear_logs();
    srcq[0] = {9'h1a1}; srcq[2] = {9'h1a2};
    drain("t7", 40);
    chk("t7_count", 32'(log_b.size()), 32'd2);
    if (log_b.size() == 2)
`ifdef UART_ARB_PRIO_EN
      chk("t7_first", 32'(log_b[0]), 32'ha1);
`else
      chk("t7_first", 32'(log_b[0]), 32'ha2);
`endif

    // randomized traffic with source gaps and TX back-pressure
    do_reset();
    total = 0;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 12; p++) begin
        int len;
        len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) begin
          srcq[i].push_back({(b == len - 1), 8'($urandom_range(255, 0))});
          total++;
        end
      end
    gap_pct = 25; rdy_pct = 70;
    drain("t8", 6000);
    chk("t8_count", 32'(log_b.size()), 32'(total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
